// File: rtl/mem_access_unit.sv
// mem_access_unit
// Memory-stage data-access engine. It turns a valid load/store from the EX/MEM
// register into one bus request/response transaction. It performs byte-lane
// steering, generates write strobes, and sign/zero-extends load data. Results
// and fault pulses are registered so they line up with the MEM/WB register.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   flush                 blocks a new access from starting (ignored once issued)
//   ex_valid              EX/MEM slot holds a valid instruction
//   ex_mem_read/write     load / store request
//   ex_funct3             [1:0] size (B/H/W/D), [2] zero-extend
//   ex_addr, ex_wdata     byte address, right-aligned store data
//   hold_out              combinational stall back to EX/MEM
//   bus_req_*             request channel (valid/ready, we, addr, wdata, wstrb)
//   bus_rsp_*             response channel (valid, rdata, err), always accepted
//   load_data_out         extended load result, held until the next load
//   mem_done              one-cycle completion pulse
//   access_fault          one-cycle pulse on a bus error response
//   misaligned            one-cycle pulse on an alignment violation
//   fault_is_store        qualifies access_fault / misaligned
//   fault_addr            faulting ex_addr
`ifndef XLEN
`define XLEN 32
`endif

module mem_access_unit #(
  parameter int XLEN = `XLEN
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [2:0]        ex_funct3,
  input  logic [XLEN-1:0]   ex_addr,
  input  logic [XLEN-1:0]   ex_wdata,
  output logic              hold_out,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic              bus_req_we,
  output logic [XLEN-1:0]   bus_req_addr,
  output logic [XLEN-1:0]   bus_req_wdata,
  output logic [XLEN/8-1:0] bus_req_wstrb,
  input  logic              bus_rsp_valid,
  input  logic [XLEN-1:0]   bus_rsp_rdata,
  input  logic              bus_rsp_err,
  output logic [XLEN-1:0]   load_data_out,
  output logic              mem_done,
  output logic              access_fault,
  output logic              misaligned,
  output logic              fault_is_store,
  output logic [XLEN-1:0]   fault_addr
);

  localparam int STRBW = XLEN / 8;
  localparam int OFFW  = $clog2(STRBW);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  // Doubleword accesses degrade to word accesses on a 32-bit datapath.
  function automatic logic [1:0] norm_size(input logic [1:0] sz);
    if (XLEN == 32 && sz == 2'b11) begin
      return 2'b10;
    end else begin
      return sz;
    end
  endfunction

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [2:0] a);
    case (sz)
      2'b00:   return 1'b0;
      2'b01:   return (a[0] != 1'b0);
      2'b10:   return (a[1:0] != 2'b00);
      2'b11:   return (a[2:0] != 3'b000);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [STRBW-1:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return STRBW'(8'h01);
      2'b01:   return STRBW'(8'h03);
      2'b10:   return STRBW'(8'h0F);
      default: return {STRBW{1'b1}};
    endcase
  endfunction

  // Left-justify the access-sized field, then shift back logically (zero
  // extend) or arithmetically (sign extend); a full-width access is a no-op.
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] d,
                                             input logic [1:0] sz,
                                             input logic uns);
    int sh;
    logic [XLEN-1:0] t;
    sh = XLEN - int'(32'd8 << sz);
    t  = d << sh;
    if (uns) begin
      return t >> sh;
    end else begin
      return $signed(t) >>> sh;
    end
  endfunction

  logic [1:0]       state_r;
  logic [XLEN-1:0]  lat_addr_r;
  logic             lat_we_r;
  logic [1:0]       lat_size_r;
  logic             lat_uns_r;
  logic [XLEN-1:0]  lat_wdata_r;
  logic [STRBW-1:0] lat_wstrb_r;

  logic [XLEN-1:0]  load_data_r;
  logic             mem_done_r;
  logic             access_fault_r;
  logic             misaligned_r;
  logic             fault_is_store_r;
  logic [XLEN-1:0]  fault_addr_r;

  logic [1:0]       size_s;
  logic [OFFW-1:0]  off_s;
  logic             req_s;
  logic             mis_s;
  logic             start_s;
  logic [XLEN-1:0]  wdata_s;
  logic [STRBW-1:0] wstrb_s;
  logic [XLEN-1:0]  rsp_shifted_s;

  // Decode the EX/MEM slot: start qualification, alignment, lane steering.
  always_comb begin
    size_s  = norm_size(ex_funct3[1:0]);
    off_s   = ex_addr[OFFW-1:0];
    req_s   = ex_valid & (ex_mem_read | ex_mem_write) & ~flush & (state_r == ST_IDLE);
    mis_s   = is_misaligned(size_s, ex_addr[2:0]);
    start_s = req_s & ~mis_s;
    wdata_s = ex_wdata << {off_s, 3'b000};
    if (ex_mem_write) begin
      wstrb_s = size_mask(size_s) << off_s;
    end else begin
      wstrb_s = {STRBW{1'b0}};
    end
    rsp_shifted_s = bus_rsp_rdata >> {lat_addr_r[OFFW-1:0], 3'b000};
  end

  // Request channel: driven straight from the slot in the start cycle,
  // from the latched copy while waiting for acceptance.
  always_comb begin
    bus_req_valid = 1'b0;
    bus_req_we    = lat_we_r;
    bus_req_addr  = {lat_addr_r[XLEN-1:OFFW], {OFFW{1'b0}}};
    bus_req_wdata = lat_wdata_r;
    bus_req_wstrb = lat_wstrb_r;
    if (state_r == ST_IDLE) begin
      bus_req_valid = start_s;
      bus_req_we    = ex_mem_write;
      bus_req_addr  = {ex_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
      bus_req_wdata = wdata_s;
      bus_req_wstrb = wstrb_s;
    end else if (state_r == ST_REQ) begin
      bus_req_valid = 1'b1;
    end else begin
      bus_req_valid = 1'b0;
    end
  end

  // Stall EX/MEM from the start cycle until the response cycle.
  always_comb begin
    hold_out = 1'b0;
    case (state_r)
      ST_IDLE: hold_out = start_s;
      ST_REQ:  hold_out = 1'b1;
      ST_WAIT: hold_out = ~bus_rsp_valid;
      default: hold_out = 1'b0;
    endcase
  end

  // Transaction FSM, request latch and registered results/fault pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r          <= ST_IDLE;
      lat_addr_r       <= {XLEN{1'b0}};
      lat_we_r         <= 1'b0;
      lat_size_r       <= 2'b00;
      lat_uns_r        <= 1'b0;
      lat_wdata_r      <= {XLEN{1'b0}};
      lat_wstrb_r      <= {STRBW{1'b0}};
      load_data_r      <= {XLEN{1'b0}};
      mem_done_r       <= 1'b0;
      access_fault_r   <= 1'b0;
      misaligned_r     <= 1'b0;
      fault_is_store_r <= 1'b0;
      fault_addr_r     <= {XLEN{1'b0}};
    end else begin
      mem_done_r     <= 1'b0;
      access_fault_r <= 1'b0;
      misaligned_r   <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req_s && mis_s) begin
            misaligned_r     <= 1'b1;
            fault_is_store_r <= ex_mem_write;
            fault_addr_r     <= ex_addr;
          end else if (start_s) begin
            lat_addr_r  <= ex_addr;
            lat_we_r    <= ex_mem_write;
            lat_size_r  <= size_s;
            lat_uns_r   <= ex_funct3[2];
            lat_wdata_r <= wdata_s;
            lat_wstrb_r <= wstrb_s;
            state_r     <= bus_req_ready ? ST_WAIT : ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus_req_ready) begin
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus_rsp_valid) begin
            state_r <= ST_IDLE;
            if (bus_rsp_err) begin
              access_fault_r   <= 1'b1;
              fault_is_store_r <= lat_we_r;
              fault_addr_r     <= lat_addr_r;
            end else begin
              mem_done_r <= 1'b1;
              if (!lat_we_r) begin
                load_data_r <= extend(rsp_shifted_s, lat_size_r, lat_uns_r);
              end
            end
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign load_data_out  = load_data_r;
  assign mem_done       = mem_done_r;
  assign access_fault   = access_fault_r;
  assign misaligned     = misaligned_r;
  assign fault_is_store = fault_is_store_r;
  assign fault_addr     = fault_addr_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit (XLEN=32). Stimulus tasks drive
// directed accesses and an emulated bus, pushing the expected completion
// into a queue; a monitor pops and compares whenever a result pulse appears.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        ex_valid;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic        hold_out;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic        bus_req_we;
  logic [31:0] bus_req_addr;
  logic [31:0] bus_req_wdata;
  logic [3:0]  bus_req_wstrb;
  logic        bus_rsp_valid;
  logic [31:0] bus_rsp_rdata;
  logic        bus_rsp_err;
  logic [31:0] load_data_out;
  logic        mem_done;
  logic        access_fault;
  logic        misaligned;
  logic        fault_is_store;
  logic [31:0] fault_addr;

  mem_access_unit #(.XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .ex_valid(ex_valid),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .hold_out(hold_out),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_we(bus_req_we),
    .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata), .bus_req_wstrb(bus_req_wstrb),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata), .bus_rsp_err(bus_rsp_err),
    .load_data_out(load_data_out), .mem_done(mem_done), .access_fault(access_fault),
    .misaligned(misaligned), .fault_is_store(fault_is_store), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // kind: 0 = mem_done, 1 = access_fault, 2 = misaligned
  typedef struct {
    int          kind;
    logic [31:0] ld;
    logic [31:0] fa;
    logic        fs;
    int          at;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] last_load = 32'h0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every result pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (reset_n && (mem_done || access_fault || misaligned)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got done=%0b fault=%0b mis=%0b expected none",
                 mem_done, access_fault, misaligned);
      end else begin
        exp_t e;
        logic [2:0] onehot;
        e = exp_q.pop_front();
        onehot = (e.kind == 0) ? 3'b100 : (e.kind == 1) ? 3'b010 : 3'b001;
        chk("pulse_kind", {61'd0, mem_done, access_fault, misaligned}, {61'd0, onehot});
        chk("pulse_cycle", 64'(cyc), 64'(e.at));
        chk("load_data", {32'd0, load_data_out}, {32'd0, e.ld});
        if (e.kind != 0) begin
          chk("fault_addr", {32'd0, fault_addr}, {32'd0, e.fa});
          chk("fault_is_store", {63'd0, fault_is_store}, {63'd0, e.fs});
        end
      end
    end
  end

  // Runs one aligned access. Called at #1 after a rising edge; returns likewise.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input int rdy, input int rsp, input logic [31:0] rdata,
                            input logic err, input logic flush_mid,
                            input logic [31:0] e_addr, input logic [31:0] e_wdata,
                            input logic [3:0] e_wstrb, input logic [31:0] e_ld,
                            input int e_hold);
    exp_t e;
    int hc;
    int rsp_at;
    logic seen;
    hc = 0;
    seen = 1'b0;
    rsp_at = rdy + 1 + rsp;
    e.kind = err ? 1 : 0;
    e.ld   = (rd && !err) ? e_ld : last_load;
    e.fa   = addr;
    e.fs   = wr;
    e.at   = cyc + rsp_at + 1;
    exp_q.push_back(e);
    last_load = e.ld;
    ex_valid = 1'b1; ex_mem_read = rd; ex_mem_write = wr;
    ex_funct3 = f3; ex_addr = addr; ex_wdata = wdata;
    bus_rsp_rdata = rdata;
    for (int c = 0; c < 40; c++) begin
      bus_req_ready = (c == rdy);
      bus_rsp_valid = (c == rsp_at);
      bus_rsp_err   = err && (c == rsp_at);
      flush         = flush_mid && (c > rdy);
      @(negedge clk);
      if (hold_out) hc++;
      if (c <= rdy) begin
        chk("req_valid", {63'd0, bus_req_valid}, 64'd1);
        chk("req_addr", {32'd0, bus_req_addr}, {32'd0, e_addr});
        chk("req_we", {63'd0, bus_req_we}, {63'd0, wr});
        chk("req_wdata", {32'd0, bus_req_wdata}, {32'd0, e_wdata});
        chk("req_wstrb", {60'd0, bus_req_wstrb}, {60'd0, e_wstrb});
      end else begin
        chk("req_dropped", {63'd0, bus_req_valid}, 64'd0);
      end
      @(posedge clk); #1;
      if (c == rsp_at) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rsp_reached", {63'd0, seen}, 64'd1);
    chk("hold_cycles", 64'(hc), 64'(e_hold));
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0; flush = 1'b0;
  endtask

  // Misaligned access: no bus request, no stall, pulse on the next cycle.
  task automatic run_mis(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr);
    exp_t e;
    e.kind = 2; e.ld = last_load; e.fa = addr; e.fs = wr; e.at = cyc + 1;
    exp_q.push_back(e);
    ex_valid = 1'b1; ex_mem_read = rd; ex_mem_write = wr; ex_funct3 = f3; ex_addr = addr;
    @(negedge clk);
    chk("mis_no_req", {63'd0, bus_req_valid}, 64'd0);
    chk("mis_no_hold", {63'd0, hold_out}, 64'd0);
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    @(negedge clk);
    chk("mis_no_req_after", {63'd0, bus_req_valid}, 64'd0);
    chk("mis_no_hold_after", {63'd0, hold_out}, 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; flush = 1'b0; ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    ex_funct3 = 3'b000; ex_addr = 32'h0; ex_wdata = 32'h0;
    bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_rdata = 32'h0; bus_rsp_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hold", {63'd0, hold_out}, 64'd0);
    chk("rst_req_valid", {63'd0, bus_req_valid}, 64'd0);
    chk("rst_outputs", {58'd0, mem_done, access_fault, misaligned, fault_is_store,
                        |load_data_out, |fault_addr}, 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // LB / LBU at 0x1003, lane 3
    run_access(1'b1, 1'b0, 3'b000, 32'h1003, 32'h0, 0, 0, 32'h8000_0000, 1'b0, 1'b0,
               32'h1000, 32'h0, 4'h0, 32'hFFFF_FF80, 1);
    run_access(1'b1, 1'b0, 3'b100, 32'h1003, 32'h0, 0, 0, 32'h8000_0000, 1'b0, 1'b0,
               32'h1000, 32'h0, 4'h0, 32'h0000_0080, 1);
    // SH at 0x2002
    run_access(1'b0, 1'b1, 3'b001, 32'h2002, 32'h0000_BEEF, 0, 0, 32'h0, 1'b0, 1'b0,
               32'h2000, 32'hBEEF_0000, 4'hC, 32'h0, 1);
    // Misaligned LW and SH
    run_mis(1'b1, 1'b0, 3'b010, 32'h3001);
    run_mis(1'b0, 1'b1, 3'b001, 32'h2001);
    // Backpressure: 3 not-ready cycles, response 2 cycles after acceptance
    run_access(1'b1, 1'b0, 3'b010, 32'h5004, 32'h0, 3, 2, 32'h1234_5678, 1'b0, 1'b0,
               32'h5004, 32'h0, 4'h0, 32'h1234_5678, 6);
    // SW with bus error
    run_access(1'b0, 1'b1, 3'b010, 32'h4000, 32'hDEAD_BEEF, 0, 0, 32'h0, 1'b1, 1'b0,
               32'h4000, 32'hDEAD_BEEF, 4'hF, 32'h0, 1);
    // LH / LHU upper half
    run_access(1'b1, 1'b0, 3'b001, 32'h6002, 32'h0, 0, 1, 32'h8001_0000, 1'b0, 1'b0,
               32'h6000, 32'h0, 4'h0, 32'hFFFF_8001, 2);
    run_access(1'b1, 1'b0, 3'b101, 32'h6002, 32'h0, 1, 0, 32'h8001_0000, 1'b0, 1'b0,
               32'h6000, 32'h0, 4'h0, 32'h0000_8001, 2);
    // SB to lane 1
    run_access(1'b0, 1'b1, 3'b000, 32'h7001, 32'h0000_00A5, 0, 0, 32'h0, 1'b0, 1'b0,
               32'h7000, 32'h0000_A500, 4'h2, 32'h0, 1);
    // Doubleword size on a 32-bit datapath behaves as a word
    run_access(1'b1, 1'b0, 3'b011, 32'h8004, 32'h0, 0, 0, 32'hCAFE_F00D, 1'b0, 1'b0,
               32'h8004, 32'h0, 4'h0, 32'hCAFE_F00D, 1);

    // Flush in IDLE blocks the access
    flush = 1'b1; ex_valid = 1'b1; ex_mem_read = 1'b1; ex_funct3 = 3'b010; ex_addr = 32'hA000;
    @(negedge clk);
    chk("flush_no_req", {63'd0, bus_req_valid}, 64'd0);
    chk("flush_no_hold", {63'd0, hold_out}, 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; ex_valid = 1'b0; ex_mem_read = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Flush during WAIT does not abort the transaction
    run_access(1'b1, 1'b0, 3'b010, 32'h9000, 32'h0, 0, 2, 32'h55AA_55AA, 1'b0, 1'b1,
               32'h9000, 32'h0, 4'h0, 32'h55AA_55AA, 3);

    // Reset while in REQ
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_funct3 = 3'b010; ex_addr = 32'hB000;
    bus_req_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("req_state_valid", {63'd0, bus_req_valid}, 64'd1);
    reset_n = 1'b0; ex_valid = 1'b0; ex_mem_read = 1'b0;
    #1;
    chk("midrst_req_valid", {63'd0, bus_req_valid}, 64'd0);
    chk("midrst_hold", {63'd0, hold_out}, 64'd0);
    chk("midrst_outputs", {58'd0, mem_done, access_fault, misaligned, fault_is_store,
                           |load_data_out, |fault_addr}, 64'd0);
    last_load = 32'h0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    // Late response in IDLE must be ignored
    bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("late_rsp_no_hold", {63'd0, hold_out}, 64'd0);
    @(posedge clk); #1;
    bus_rsp_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Normal operation resumes (back-to-back pair)
    run_access(1'b1, 1'b0, 3'b010, 32'hC000, 32'h0, 0, 0, 32'h0102_0304, 1'b0, 1'b0,
               32'hC000, 32'h0, 4'h0, 32'h0102_0304, 1);
    run_access(1'b0, 1'b1, 3'b010, 32'hC004, 32'h1111_2222, 0, 0, 32'h0, 1'b0, 1'b0,
               32'hC004, 32'h1111_2222, 4'hF, 32'h0, 1);

    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage data-access engine that consumes the EX/MEM pipeline register outputs and drives the data bus. It turns a valid load/store into a single bus request/response transaction, with byte-lane steering, write strobes, and load sign/zero extension. It asserts `hold_out` back to the EX/MEM register until the transaction completes. Results are registered so they line up with the MEM/WB register.

## Interface
- `XLEN`, default `` `XLEN ``: data/address width, 32 or 64.
- `clk`  in  1  clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  trap/exception flush; blocks a new access from starting.
- `ex_valid`  in  1  EX/MEM slot holds a valid instruction.
- `ex_mem_read` / `ex_mem_write`  in  1 each  load/store request.
- `ex_funct3`  in  3  access size and signedness.
- `ex_addr`  in  XLEN  physical byte address.
- `ex_wdata`  in  XLEN  store data, right-aligned.
- `hold_out`  out  1  stalls the EX/MEM register; combinational.
- `bus_req_valid`  out  1  request valid.
- `bus_req_ready`  in  1  request accepted.
- `bus_req_we`  out  1  1 = store.
- `bus_req_addr`  out  XLEN  address aligned to XLEN/8 bytes.
- `bus_req_wdata`  out  XLEN  lane-shifted store data.
- `bus_req_wstrb`  out  XLEN/8  byte enables; 0 for loads.
- `bus_rsp_valid`  in  1  response valid; always accepted.
- `bus_rsp_rdata`  in  XLEN  read data.
- `bus_rsp_err`  in  1  access error.
- `load_data_out`  out  XLEN  extended load result.
- `mem_done`  out  1  one-cycle completion pulse (load or store).
- `access_fault`  out  1  one-cycle pulse on `bus_rsp_err`.
- `misaligned`  out  1  one-cycle pulse on an alignment violation.
- `fault_is_store`  out  1  qualifies `access_fault` / `misaligned`.
- `fault_addr`  out  XLEN  faulting `ex_addr`.

## Operation
- Reset: state IDLE. Every output register is 0. `hold_out` and `bus_req_valid` are 0.
- Access start condition: `start = ex_valid & (ex_mem_read | ex_mem_write) & !flush & state==IDLE`.
- Size: `ex_funct3[1:0]` selects the access size: 00 = byte, 01 = half, 10 = word, 11 = double. On XLEN=32, 11 is treated as word.
- Load extension: `ex_funct3[2]` = 1 means zero-extend (LBU/LHU/LWU); otherwise sign-extend.
- Misalignment: half requires `addr[0]`==0, word requires `addr[1:0]`==0, double requires `addr[2:0]`==0.
  - A misaligned `start` skips the bus and stays IDLE.
  - `misaligned`, `fault_is_store`, and `fault_addr` are registered and valid on the next cycle.
  - `hold_out` stays 0 for a misaligned access.
- Lanes: `off = addr[log2(XLEN/8)-1:0]`.
  - `bus_req_addr = addr` with the `off` bits cleared.
  - `wdata = ex_wdata << (8*off)`.
  - `wstrb = size_mask << off`, where `size_mask` is 1, 3, F, or FF.
- State machine (IDLE → REQ → WAIT → IDLE):
  - IDLE: an aligned `start` sets `bus_req_valid` combinationally in the same cycle. If `bus_req_ready`, go to WAIT; else go to REQ and latch the request fields.
  - REQ: hold `bus_req_valid` with stable fields until `bus_req_ready`, then go to WAIT.
  - WAIT: on `bus_rsp_valid`, go to IDLE.
    - Loads: register `load_data_out = ext(rdata >> 8*off)`.
    - Loads and stores: pulse `mem_done`.
    - If `bus_rsp_err`: pulse `access_fault` instead of `mem_done`; `fault_addr` and `fault_is_store` are registered.
- `hold_out = (state==IDLE & aligned start) | state==REQ | (state==WAIT & !bus_rsp_valid)`.
- A response in the same cycle as request acceptance (IDLE or REQ) is not permitted by the bus.
- `flush` is ignored outside IDLE: an issued transaction always completes, and `hold_out` keeps priority over the EX/MEM flush.
- `load_data_out` holds its value until the next load completes. `mem_done` and the fault pulses last exactly one cycle.
- Reset mid-transaction: return to IDLE immediately and drop the request. Any late `bus_rsp_valid` arriving in IDLE is ignored.

## Timing
- Zero-wait bus (ready in the start cycle, response one cycle later):
  - Start cycle: `hold_out`=1.
  - Response cycle: `hold_out`=0.
  - `mem_done` and `load_data_out` are valid in the cycle after the response, coincident with the instruction in MEM/WB.
- Minimum latency is 2 cycles from start to `mem_done`. Each cycle of `ready` backpressure or response delay adds one cycle.
- Back-to-back: a new access can start in the cycle immediately after the response cycle.

## Test plan
- XLEN=32, LB at `addr=0x1003`, `rdata=0x80_00_00_00`:
  - `bus_req_addr=0x1000`, `wstrb=0`.
  - `load_data_out=0xFFFFFF80`, `mem_done` pulse 2 cycles after start.
  - LBU of the same data gives `0x00000080`.
- SH at `addr=0x2002`, `wdata=0x0000BEEF`: `wstrb=0b1100`, `bus_req_wdata=0xBEEF0000`, `bus_req_we=1`, `mem_done` pulse, no `load_data_out` change.
- LW at `addr=0x3001`: `misaligned`=1 for one cycle, `fault_addr=0x3001`, `fault_is_store=0`, no `bus_req_valid`, `hold_out` never 1.
- Backpressure: `bus_req_ready`=0 for 3 cycles, response 2 cycles after acceptance:
  - `bus_req_valid` and fields stable for 4 cycles.
  - `hold_out`=1 for 6 cycles.
  - `mem_done` in cycle 8.
- `bus_rsp_err`=1 on an SW to `0x4000`: `access_fault` pulse, `fault_is_store=1`, `fault_addr=0x4000`, no `mem_done`.
- Flush and reset:
  - `flush`=1 with a valid load in IDLE: no request.
  - `flush` asserted while in WAIT: the transaction still completes.
  - `reset_n` low while in REQ: all outputs go to 0 and the state returns to IDLE.
